// File: rtl/hex_rate_counter.sv
// hex_rate_counter: 4-bit hex counter advanced by a selectable-rate divider.
// The divider is a down-counter reloaded with R(sel). A step fires on the
// enabled edge where it has reached zero. step and wrap are registered
// alongside digit, so they line up with the cycle showing the new value.
module hex_rate_counter #(
    parameter int TICKS_1HZ = 50000000,
    parameter int DIV_W     = 28
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] sel,
    input  logic       dir,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic [3:0] digit,
    output logic       step,
    output logic       wrap
);

    localparam logic [DIV_W-1:0] R_1HZ   = DIV_W'(TICKS_1HZ - 1);
    localparam logic [DIV_W-1:0] R_HALF  = DIV_W'(2 * TICKS_1HZ - 1);
    localparam logic [DIV_W-1:0] R_QUART = DIV_W'(4 * TICKS_1HZ - 1);

    logic [DIV_W-1:0] rate_cnt;
    logic [DIV_W-1:0] reload;
    logic [1:0]       sel_q;
    logic             wrap_next;

    // reload value for the currently requested rate
    always_comb begin
        reload = '0;
        case (sel)
            2'b00:   reload = '0;
            2'b01:   reload = R_1HZ;
            2'b10:   reload = R_HALF;
            default: reload = R_QUART;
        endcase
    end

    // wrap happens when leaving F going up or leaving 0 going down
    always_comb begin
        wrap_next = dir ? (digit == 4'hF) : (digit == 4'h0);
    end

    // divider, digit and pulse registers with load > rate change > hold > count
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rate_cnt <= '0;
            sel_q    <= 2'b00;
            digit    <= 4'h0;
            step     <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            sel_q <= sel;
            step  <= 1'b0;
            wrap  <= 1'b0;
            if (load) begin
                digit    <= load_value;
                rate_cnt <= reload;
            end else if (sel != sel_q) begin
                rate_cnt <= reload;
            end else if (enable) begin
                if (rate_cnt != '0) begin
                    rate_cnt <= rate_cnt - 1'b1;
                end else begin
                    rate_cnt <= reload;
                    digit    <= dir ? digit + 4'h1 : digit - 4'h1;
                    step     <= 1'b1;
                    wrap     <= wrap_next;
                end
            end
        end
    end

endmodule
